// File: rtl/econet_rx_buffer.sv
// Econet receive buffer: filters frames by destination station, checks the FCS
// residue at frame end and holds one good frame for random-access host reads.
module econet_rx_buffer #(
    parameter int          ADDR_W       = 8,
    parameter logic [15:0] GOOD_RESIDUE = 16'hF0B8,
    parameter int          MIN_LEN      = 6
) (
    input  logic              econet_clk,
    input  logic              reset,
    input  logic [7:0]        station_id,
    input  logic              promisc,
    input  logic [7:0]        rx_byte,
    input  logic              rx_byte_ready,
    input  logic              rx_frame_start,
    input  logic              rx_frame_end,
    input  logic [15:0]       rx_fcs,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              frame_valid,
    output logic [ADDR_W:0]   frame_len,
    input  logic              frame_ack,
    output logic [7:0]        drop_count
);

    typedef enum logic [1:0] {IDLE, RECV, DISCARD, HOLD} state_t;

    localparam logic [ADDR_W:0] CAPACITY  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] MIN_COUNT = (ADDR_W + 1)'(MIN_LEN);

    state_t          state_reg, state_next;
    logic [ADDR_W:0] count_reg, count_next;
    logic [ADDR_W:0] frame_len_reg, frame_len_next;
    logic [7:0]      drop_count_reg;
    logic [7:0]      rd_data_reg;
    logic            drop_inc;
    logic            mem_we;
    logic            addr_reject;

    logic [7:0] mem [2**ADDR_W];

    assign addr_reject = (rx_byte != station_id) && (rx_byte != 8'hFF) && !promisc;

    always_ff @(posedge econet_clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            frame_len_reg  <= '0;
            drop_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            frame_len_reg <= frame_len_next;
            if (drop_inc && drop_count_reg != 8'hFF)
                drop_count_reg <= drop_count_reg + 8'd1;
        end
    end

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        frame_len_next = frame_len_reg;
        drop_inc       = 1'b0;
        mem_we         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (rx_frame_start) begin
                    state_next = RECV;
                    count_next = '0;
                end
            end
            RECV: begin
                if (rx_frame_start) begin
                    count_next = '0;
                end else begin
                    // A byte in the same cycle as frame end is counted before the end checks.
                    if (rx_byte_ready && count_reg == CAPACITY) begin
                        drop_inc   = 1'b1;
                        state_next = rx_frame_end ? IDLE : DISCARD;
                    end else if (rx_byte_ready && count_reg == '0 && addr_reject) begin
                        mem_we     = 1'b1;
                        count_next = count_reg + (ADDR_W + 1)'(1);
                        state_next = rx_frame_end ? IDLE : DISCARD;
                    end else begin
                        if (rx_byte_ready) begin
                            mem_we     = 1'b1;
                            count_next = count_reg + (ADDR_W + 1)'(1);
                        end
                        if (rx_frame_end) begin
                            if (count_next < MIN_COUNT || rx_fcs != GOOD_RESIDUE) begin
                                drop_inc   = 1'b1;
                                state_next = IDLE;
                            end else begin
                                state_next     = HOLD;
                                frame_len_next = count_next - (ADDR_W + 1)'(2);
                            end
                        end
                    end
                end
            end
            DISCARD: begin
                if (rx_frame_start) begin
                    state_next = RECV;
                    count_next = '0;
                end else if (rx_frame_end) begin
                    state_next = IDLE;
                end
            end
            HOLD: begin
                // Ack takes priority so a back-to-back frame is not lost.
                if (frame_ack) begin
                    state_next = rx_frame_start ? RECV : IDLE;
                    count_next = '0;
                end else if (rx_frame_start) begin
                    drop_inc = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        frame_valid = (state_reg == HOLD);
    end

    always_ff @(posedge econet_clk) begin
        if (mem_we)
            mem[count_reg[ADDR_W-1:0]] <= rx_byte;
    end

    always_ff @(posedge econet_clk or posedge reset) begin
        if (reset)
            rd_data_reg <= '0;
        else
            rd_data_reg <= mem[rd_addr];
    end

    assign rd_data    = rd_data_reg;
    assign frame_len  = frame_len_reg;
    assign drop_count = drop_count_reg;

endmodule
